gcd_lcm_engine: RTL and testbench

- Parametrised successor to the fixed 4-bit GCD controller/datapath used on the lab board.
- Computes GCD or LCM of two unsigned WIDTH-bit operands using a subtract/add iterative datapath under a small controller FSM.
- Generalised in operand width, with an operation-mode select, rising-edge start detection, zero-operand error flag and an iteration counter.
- Instantiated by a board top the same way as its predecessor: switches/DIPs to X/Y, buttons to START/RESET, LEDs to RESULT/DONE.

---
 rtl/gcd_lcm_engine.sv | 141 ++++++++++++++
 tb/tb_gcd_lcm_engine.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/gcd_lcm_engine.sv
// Iterative GCD/LCM engine: GCD by repeated subtraction, LCM by stepping
// multiples of each operand until they meet, both under a small IDLE/RUN/FIN controller.
module gcd_lcm_engine #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 START,
  input  logic                 MODE,
  input  logic [WIDTH-1:0]     X,
  input  logic [WIDTH-1:0]     Y,
  output logic [2*WIDTH-1:0]   RESULT,
  output logic                 DONE,
  output logic                 BUSY,
  output logic                 ERR,
  output logic [CNT_W-1:0]     ITERS
);

  localparam int W2 = 2 * WIDTH;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FIN = 2'd2} state_t;

  state_t           state_reg, state_next;
  logic             start_q_reg;
  logic             mode_reg, mode_next;
  logic [W2-1:0]    a_reg, a_next, b_reg, b_next;
  logic [WIDTH-1:0] xs_reg, xs_next, ys_reg, ys_next;
  logic [W2-1:0]    result_reg, result_next;
  logic             done_reg, done_next, busy_reg, busy_next, err_reg, err_next;
  logic [CNT_W-1:0] iters_reg, iters_next;

  logic             launch, zero_case, equal_ops;
  logic [W2-1:0]    xs_ext, ys_ext;

  assign launch    = START & ~start_q_reg & (state_reg != RUN);
  assign xs_ext    = {{WIDTH{1'b0}}, xs_reg};
  assign ys_ext    = {{WIDTH{1'b0}}, ys_reg};
  assign zero_case = mode_reg ? ((xs_reg == '0) || (ys_reg == '0))
                              : ((a_reg == '0) || (b_reg == '0));
  assign equal_ops = (a_reg == b_reg);

  // start_q keeps following the button under reset, so a press held through
  // reset release is not mistaken for a fresh rising edge.
  always_ff @(posedge CLK) begin
    start_q_reg <= START;
    if (RESET) begin
      state_reg  <= IDLE;
      mode_reg   <= 1'b0;
      a_reg      <= '0;
      b_reg      <= '0;
      xs_reg     <= '0;
      ys_reg     <= '0;
      result_reg <= '0;
      done_reg   <= 1'b0;
      busy_reg   <= 1'b0;
      err_reg    <= 1'b0;
      iters_reg  <= '0;
    end else begin
      state_reg  <= state_next;
      mode_reg   <= mode_next;
      a_reg      <= a_next;
      b_reg      <= b_next;
      xs_reg     <= xs_next;
      ys_reg     <= ys_next;
      result_reg <= result_next;
      done_reg   <= done_next;
      busy_reg   <= busy_next;
      err_reg    <= err_next;
      iters_reg  <= iters_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE, FIN: if (launch) state_next = RUN;
      RUN:       if (zero_case || equal_ops) state_next = FIN;
      default:   state_next = IDLE;
    endcase
  end

  always_comb begin
    mode_next   = mode_reg;
    a_next      = a_reg;
    b_next      = b_reg;
    xs_next     = xs_reg;
    ys_next     = ys_reg;
    result_next = result_reg;
    done_next   = done_reg;
    busy_next   = busy_reg;
    err_next    = err_reg;
    iters_next  = iters_reg;

    if (launch) begin
      a_next     = {{WIDTH{1'b0}}, X};
      b_next     = {{WIDTH{1'b0}}, Y};
      xs_next    = X;
      ys_next    = Y;
      mode_next  = MODE;
      iters_next = '0;
      done_next  = 1'b0;
      err_next   = 1'b0;
      busy_next  = 1'b1;
    end else if (state_reg == RUN) begin
      if (zero_case) begin
        // LCM with a zero operand is undefined; GCD(0,n)=n is legal.
        if (mode_reg) begin
          result_next = '0;
          err_next    = 1'b1;
        end else begin
          result_next = a_reg | b_reg;
          err_next    = (a_reg == '0) && (b_reg == '0);
        end
      end else if (equal_ops) begin
        result_next = a_reg;
        err_next    = 1'b0;
      end else begin
        if (iters_reg != '1) iters_next = iters_reg + CNT_W'(1);
        if (mode_reg) begin
          if (a_reg < b_reg) a_next = a_reg + xs_ext;
          else               b_next = b_reg + ys_ext;
        end else begin
          if (a_reg > b_reg) a_next = a_reg - b_reg;
          else               b_next = b_reg - a_reg;
        end
      end
      if (zero_case || equal_ops) begin
        done_next = 1'b1;
        busy_next = 1'b0;
      end
    end
  end

  assign RESULT = result_reg;
  assign DONE   = done_reg;
  assign BUSY   = busy_reg;
  assign ERR    = err_reg;
  assign ITERS  = iters_reg;

endmodule

// File: tb/tb_gcd_lcm_engine.sv
// Directed and randomized bench for gcd_lcm_engine; expected results come
// from Euclid's algorithm and LCM = x*y/gcd, with step counts from quotient sums.
module tb_gcd_lcm_engine;

  localparam int WIDTH = 8;
  localparam int CNT_W = 16;

  logic               CLK = 1'b0;
  logic               RESET, START, MODE;
  logic [WIDTH-1:0]   X, Y;
  logic [2*WIDTH-1:0] RESULT;
  logic               DONE, BUSY, ERR;
  logic [CNT_W-1:0]   ITERS;

  int tests = 0;
  int fails = 0;

  gcd_lcm_engine #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .RESET(RESET), .START(START), .MODE(MODE), .X(X), .Y(Y),
    .RESULT(RESULT), .DONE(DONE), .BUSY(BUSY), .ERR(ERR), .ITERS(ITERS)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Subtractive GCD takes (sum of Euclid quotients - 1) steps; LCM walks
  // L/x-1 multiples of x and L/y-1 multiples of y.
  task automatic model(input bit m, input int x, input int y,
                       output int res, output bit err, output int iters);
    int a, b, t, qsum, g;
    a = x; b = y; qsum = 0;
    while (b != 0) begin
      qsum += a / b;
      t = a % b;
      a = b;
      b = t;
    end
    g = a;
    if (!m) begin
      if (x == 0 || y == 0) begin
        res = x | y; err = (x == 0 && y == 0); iters = 0;
      end else begin
        res = g; err = 1'b0; iters = qsum - 1;
      end
    end else begin
      if (x == 0 || y == 0) begin
        res = 0; err = 1'b1; iters = 0;
      end else begin
        res = (x / g) * y; err = 1'b0;
        iters = res / x + res / y - 2;
      end
    end
  endtask

  // Leaves START high after the launch edge; the caller decides when to drop it.
  task automatic launch_op(input bit m, input int x, input int y);
    START = 1'b0;
    @(posedge CLK); #1;
    MODE = m; X = x[WIDTH-1:0]; Y = y[WIDTH-1:0]; START = 1'b1;
    @(posedge CLK); #1;
    check("launch_busy", BUSY, 1);
    check("launch_done", DONE, 0);
  endtask

  task automatic finish_op(input bit m, input int x, input int y, input bit scramble);
    int res, iters, cycles;
    bit err;
    model(m, x, y, res, err, iters);
    cycles = 0;
    while (!DONE && cycles < 2000) begin
      @(posedge CLK); #1;
      cycles++;
      if (scramble) begin
        X = WIDTH'($urandom); Y = WIDTH'($urandom); MODE = 1'($urandom);
      end
    end
    check("done_timeout", DONE, 1);
    check("result", RESULT, res);
    check("err", ERR, err);
    check("iters", ITERS, iters);
    check("busy_fin", BUSY, 0);
    check("latency", cycles, iters + 1);
    $display("[TB] %s(%0d,%0d): result=%0d err=%0b iters=%0d latency=%0d",
             m ? "LCM" : "GCD", x, y, RESULT, ERR, ITERS, cycles);
  endtask

  task automatic op(input bit m, input int x, input int y);
    launch_op(m, x, y);
    START = 1'b0;
    finish_op(m, x, y, 1'b0);
  endtask

  initial begin
    bit m;
    int x, y;
    RESET = 1'b1; START = 1'b0; MODE = 1'b0; X = '0; Y = '0;
    repeat (2) @(posedge CLK);
    #1;
    check("rst_result", RESULT, 0);
    check("rst_done", DONE, 0);
    check("rst_busy", BUSY, 0);
    check("rst_err", ERR, 0);
    check("rst_iters", ITERS, 0);
    RESET = 1'b0;

    op(1'b0, 12, 18);
    op(1'b1, 4, 6);
    op(1'b1, 255, 254);
    op(1'b0, 0, 9);
    op(1'b0, 0, 0);
    op(1'b1, 0, 5);

    // Held START: one launch only, result stays put.
    launch_op(1'b0, 7, 7);
    finish_op(1'b0, 7, 7, 1'b0);
    for (int i = 0; i < 200; i++) begin
      @(posedge CLK); #1;
      check("held_done", DONE, 1);
      check("held_iters", ITERS, 0);
    end
    op(1'b0, 9, 6);

    // Inputs wiggling during RUN must not disturb the operation.
    launch_op(1'b0, 48, 36);
    START = 1'b0;
    finish_op(1'b0, 48, 36, 1'b1);

    // Reset mid-run, with START held across reset release.
    launch_op(1'b0, 200, 1);
    START = 1'b0;
    repeat (10) @(posedge CLK);
    #1;
    check("midrun_busy", BUSY, 1);
    RESET = 1'b1; START = 1'b1;
    @(posedge CLK); #1;
    check("mrst_result", RESULT, 0);
    check("mrst_done", DONE, 0);
    check("mrst_busy", BUSY, 0);
    check("mrst_err", ERR, 0);
    check("mrst_iters", ITERS, 0);
    RESET = 1'b0;
    repeat (5) @(posedge CLK);
    #1;
    check("held_nolaunch_busy", BUSY, 0);
    check("held_nolaunch_done", DONE, 0);
    op(1'b0, 200, 1);

    for (int i = 0; i < 25; i++) begin
      m = 1'($urandom_range(0, 1));
      x = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 255));
      y = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 255));
      op(m, x, y);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
